// File: rtl/bidir_pio_pkg.sv
// Shared constants for the bidirectional PIO: register word addresses and
// edge-capture mode encodings.
package bidir_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/bidir_pio_sync.sv
// Multi-flop synchroniser bringing asynchronous pin levels into the clk domain.
module bidir_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_pio.sv
// Avalon-MM bidirectional parallel I/O with per-pin direction, atomic set/clear,
// synchronised inputs, edge capture and a masked level interrupt.
module bidir_pio
  import bidir_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] pin_dly;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_next;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^(writedata >> WIDTH);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
  end

  bidir_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (bidir_port),
    .q      (pin_sync)
  );

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = pin_dly & ~pin_sync;
      EDGE_ANY:  edge_det = pin_dly ^ pin_sync;
      default:   edge_det = ~pin_dly & pin_sync;
    endcase
  end

  assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      data_dir <= RESET_DIR;
      irq_mask <= '0;
      edgecap  <= '0;
      pin_dly  <= '0;
    end else begin
      pin_dly <= pin_sync;
      // A fresh edge takes priority over a same-cycle write-1-to-clear.
      edgecap <= (edgecap & ~cap_clr) | edge_det;
      if (wr_en) begin
        case (address)
          ADDR_DATA:    data_out <= wdata;
          ADDR_DIR:     data_dir <= wdata;
          ADDR_IRQMASK: irq_mask <= wdata;
          ADDR_OUTSET:  data_out <= data_out | wdata;
          ADDR_OUTCLR:  data_out <= data_out & ~wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = pin_sync;
      ADDR_DIR:     rd_next[WIDTH-1:0] = data_dir;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:      rd_next = '0;
    endcase
  end

  // Reads sample current register state, so a concurrent write is not yet visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edgecap & irq_mask);

endmodule

// File: tb/tb_bidir_pio.sv
// Scoreboard bench for bidir_pio: an 8-bit rising-edge instance and a 32-bit
// any-edge instance share one Avalon bus with separate chip selects.
module tb_bidir_pio;
  import bidir_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs8, cs32, write_n;
  logic [31:0] writedata;
  logic [31:0] readdata8, readdata32;
  logic        irq8, irq32;
  wire  [7:0]  pins8;
  wire  [31:0] pins32;
  logic [7:0]  tb_oe8, tb_val8;
  logic [31:0] tb_oe32, tb_val32;

  bit          rd_req8 = 0, rd_req32 = 0, rd_vld8 = 0, rd_vld32 = 0;
  logic [31:0] q8_exp[$], q32_exp[$];
  string       q8_nm[$], q32_nm[$];
  int          n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_drv8
    assign pins8[i] = tb_oe8[i] ? tb_val8[i] : 1'bz;
  end
  for (genvar i = 0; i < 32; i++) begin : g_drv32
    assign pins32[i] = tb_oe32[i] ? tb_val32[i] : 1'bz;
  end

  bidir_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_DIR(8'h00)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
    .write_n(write_n), .writedata(writedata), .readdata(readdata8),
    .irq(irq8), .bidir_port(pins8));

  bidir_pio #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_DIR(32'h0000000F)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
    .write_n(write_n), .writedata(writedata), .readdata(readdata32),
    .irq(irq32), .bidir_port(pins32));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input bit sel32, input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0; cs8 = !sel32; cs32 = sel32;
    @(posedge clk); #1;
    write_n = 1'b1; cs8 = 1'b0; cs32 = 1'b0;
  endtask

  task automatic rd(input bit sel32, input logic [2:0] a, input logic [31:0] e, input string nm);
    address = a;
    if (sel32) begin q32_exp.push_back(e); q32_nm.push_back(nm); rd_req32 = 1; end
    else       begin q8_exp.push_back(e);  q8_nm.push_back(nm);  rd_req8 = 1;  end
    @(posedge clk); #1;
    rd_req8 = 0; rd_req32 = 0;
  endtask

  always @(posedge clk) begin
    rd_vld8  <= rd_req8;
    rd_vld32 <= rd_req32;
  end

  always @(negedge clk) begin
    if (rd_vld8) begin
      if (q8_exp.size() == 0) check("q8_underflow", 32'd1, 32'd0);
      else check(q8_nm.pop_front(), readdata8, q8_exp.pop_front());
    end
    if (rd_vld32) begin
      if (q32_exp.size() == 0) check("q32_underflow", 32'd1, 32'd0);
      else check(q32_nm.pop_front(), readdata32, q32_exp.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; address = '0; cs8 = 0; cs32 = 0; write_n = 1; writedata = '0;
    tb_oe8 = 8'hFF; tb_val8 = 8'h00; tb_oe32 = 32'hFFFF_FFF0; tb_val32 = '0;
    #2;
    check("rst_rd8", readdata8, 32'h0);
    check("rst_rd32", readdata32, 32'h0);
    check("rst_irq8", {31'b0, irq8}, 32'h0);
    check("rst_irq32", {31'b0, irq32}, 32'h0);
    check("rst_p32lo", {28'b0, pins32[3:0]}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);

    // Output drive and synchronised readback
    tb_oe8 = 8'h00;
    wr(0, ADDR_DIR, 32'hFF);
    wr(0, ADDR_DATA, 32'hA5);
    check("pins_a5", {24'b0, pins8}, 32'hA5);
    idle(2);
    rd(0, ADDR_DATA, 32'h0000_00A5, "rd_data_a5");
    rd(0, ADDR_EDGECAP, 32'hA5, "cap_out_edges");
    rd(0, ADDR_DIR, 32'hFF, "rd_dir");
    wr(0, ADDR_EDGECAP, 32'hFF);
    rd(0, ADDR_EDGECAP, 32'h0, "cap_cleared");

    // Set / clear and unmapped addresses
    wr(0, ADDR_DATA, 32'h0F);
    wr(0, ADDR_OUTSET, 32'h30);
    wr(0, ADDR_OUTCLR, 32'h01);
    check("pins_3e", {24'b0, pins8}, 32'h3E);
    rd(0, ADDR_OUTSET, 32'h0, "rd_outset");
    rd(0, ADDR_OUTCLR, 32'h0, "rd_outclr");
    wr(0, 3'd7, 32'hFF);
    check("pins_after_a7", {24'b0, pins8}, 32'h3E);
    rd(0, 3'd6, 32'h0, "rd_a6");
    rd(0, 3'd7, 32'h0, "rd_a7");
    rd(0, ADDR_DATA, 32'h3E, "rd_data_3e");
    rd(0, ADDR_EDGECAP, 32'h3A, "cap_rises_3a");
    wr(0, ADDR_EDGECAP, 32'hFF);
    wr(0, ADDR_DIR, 32'h00);
    tb_val8 = 8'h00; tb_oe8 = 8'hFF;
    idle(4);
    wr(0, ADDR_EDGECAP, 32'hFF);
    rd(0, ADDR_EDGECAP, 32'h0, "cap_idle");

    // Input edge latency and interrupt
    wr(0, ADDR_IRQMASK, 32'h01);
    tb_val8 = 8'h01;
    idle(2);
    check("irq_lat2", {31'b0, irq8}, 32'h0);
    idle(1);
    check("irq_lat3", {31'b0, irq8}, 32'h1);
    rd(0, ADDR_EDGECAP, 32'h01, "cap_pin0");
    wr(0, ADDR_EDGECAP, 32'h01);
    check("irq_clr", {31'b0, irq8}, 32'h0);

    // Edge coincident with write-1-to-clear
    tb_val8 = 8'h05; idle(3);
    tb_val8 = 8'h01; idle(3);
    tb_val8 = 8'h05; idle(2);
    wr(0, ADDR_EDGECAP, 32'h04);
    rd(0, ADDR_EDGECAP, 32'h04, "cap_edge_wins");
    check("irq_unmasked_bit", {31'b0, irq8}, 32'h0);
    wr(0, ADDR_EDGECAP, 32'h04);
    rd(0, ADDR_EDGECAP, 32'h0, "cap_bit2_clr");

    // 32-bit any-edge instance
    tb_val32 = 32'h8000_0000; idle(3);
    rd(1, ADDR_EDGECAP, 32'h8000_0000, "c32_rise");
    wr(1, ADDR_EDGECAP, 32'hFFFF_FFFF);
    rd(1, ADDR_EDGECAP, 32'h0, "c32_clr");
    tb_val32 = 32'h0; idle(3);
    rd(1, ADDR_EDGECAP, 32'h8000_0000, "c32_fall");
    check("irq32_masked", {31'b0, irq32}, 32'h0);
    wr(1, ADDR_EDGECAP, 32'hFFFF_FFFF);

    // Asynchronous reset mid-operation
    wr(1, ADDR_DATA, 32'h5);
    check("p32lo_5", {28'b0, pins32[3:0]}, 32'h5);
    tb_val8 = 8'h00; idle(3);
    tb_val8 = 8'h01; idle(3);
    check("irq8_set", {31'b0, irq8}, 32'h1);
    rd(0, ADDR_IRQMASK, 32'h01, "rd_mask");
    @(negedge clk); #1;
    reset_n = 1'b0;
    tb_val8 = 8'h00;
    #1;
    check("arst_irq8", {31'b0, irq8}, 32'h0);
    check("arst_rd8", readdata8, 32'h0);
    check("arst_rd32", readdata32, 32'h0);
    check("arst_p32lo", {28'b0, pins32[3:0]}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    rd(0, ADDR_EDGECAP, 32'h0, "post_cap8");
    rd(0, ADDR_DIR, 32'h0, "post_dir8");
    rd(0, ADDR_IRQMASK, 32'h0, "post_mask8");
    rd(1, ADDR_DIR, 32'h0000_000F, "post_dir32");
    rd(1, ADDR_DATA, 32'h0, "post_data32");
    rd(1, ADDR_EDGECAP, 32'h0, "post_cap32");

    idle(2);
    check("queue_drain", q8_exp.size() + q32_exp.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bidir_pio.md
BIDIR_PIO -- requirements
Module: bidir_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning number of bidirectional pins (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth (2..4).
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, meaning capture edge: 0 rising, 1 falling, 2 any.
REQ-004 The block SHALL have parameter RESET_DIR, default 0, meaning data_dir reset value (WIDTH bits, 1 = output).
REQ-005 The block SHALL have port clk, input, 1, system clock.
REQ-006 The block SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port address, input, 3, Avalon-MM word address.
REQ-008 The block SHALL have port chipselect, input, 1, slave select.
REQ-009 The block SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 The block SHALL have port writedata, input, 32, write data; bits above WIDTH ignored.
REQ-011 The block SHALL have port readdata, output, 32, registered read data, zero-extended above WIDTH.
REQ-012 The block SHALL have port irq, output, 1, level interrupt request.
REQ-013 The block SHALL have port bidir_port, inout, WIDTH, tristate pins.

Function
REQ-014 Register map SHALL be: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR; addresses 6-7 read 0 and ignore writes.
REQ-015 A write SHALL occur on a clk edge with chipselect=1 and write_n=0.
REQ-016 A write to DATA SHALL load data_out; a write to DIR, data_dir; a write to IRQMASK, irq_mask.
REQ-017 A write to OUTSET SHALL do data_out |= writedata; a write to OUTCLR, data_out &= ~writedata; both SHALL read back 0.
REQ-018 Each bidir_port[i] SHALL be driven with data_out[i] when data_dir[i]=1, otherwise high-Z.
REQ-019 Pin inputs SHALL pass through a SYNC_STAGES-flop synchroniser; DATA reads SHALL return the synchronised value.
REQ-020 An edge SHALL be detected by comparing the synchronised value with its one-cycle-delayed copy, per EDGE_TYPE.
REQ-021 A detected edge on bit i SHALL set edgecap[i] on the following clk edge, regardless of data_dir[i] and irq_mask[i].
REQ-022 A write to EDGECAP SHALL clear every bit where writedata is 1 (write-1-to-clear).
REQ-023 When an edge on bit i and a clear of bit i coincide, edgecap[i] SHALL be set (edge wins).
REQ-024 irq SHALL equal |(edgecap & irq_mask), driven from registers only (glitch-free).
REQ-025 readdata SHALL be updated on every clk edge from address (no chipselect qualification); read latency 1 cycle.
REQ-026 A simultaneous write and read of the same register SHALL return the pre-write value.
REQ-027 Pin-to-edgecap latency SHALL be SYNC_STAGES+1 clk cycles.

Reset
REQ-028 While reset_n=0: data_out=0, data_dir=RESET_DIR, irq_mask=0, edgecap=0, readdata=0, synchroniser and delay flops=0, irq=0.
REQ-029 Reset assertion SHALL take effect immediately without clk; deassertion SHALL be used synchronised externally.
REQ-030 No edge SHALL be captured in the first cycle after reset from the synchroniser's 0 initial state for EDGE_TYPE 0/2 unless a real 0->1 transition propagates.

Structure
REQ-031 Package bidir_pio_pkg SHALL hold the register address constants and EDGE_TYPE encodings.
REQ-032 Sub-module bidir_pio_sync SHALL implement the WIDTH-wide SYNC_STAGES synchroniser; all other logic SHALL be in bidir_pio.

Verification
REQ-033 Reset, write DIR=0xFF, DATA=0xA5 -> bidir_port=0xA5; read DATA after sync -> readdata=0x000000A5.
REQ-034 DATA=0x0F, OUTSET 0x30, OUTCLR 0x01 -> data_out=0x3E; reads of OUTSET/OUTCLR return 0.
REQ-035 DIR=0, IRQMASK=0x01, drive pin0 0->1 (EDGE_TYPE 0) -> EDGECAP=0x01 after 3 cycles, irq=1; write EDGECAP 0x01 -> irq=0.
REQ-036 Edge on pin2 in same cycle as EDGECAP write 0x04 -> EDGECAP bit2 remains 1.
REQ-037 EDGE_TYPE 2, WIDTH 32, toggle pin31 1->0 -> EDGECAP=0x80000000; IRQMASK=0 -> irq stays 0.
REQ-038 Assert reset_n mid-operation with irq=1 -> irq, readdata, edgecap, data_out go to 0 and bidir_port returns to RESET_DIR state without a clk edge.
